// File: rtl/key_evt_defs.sv
// Shared state encodings and default timing constants
// for the front-panel key event classifier.
package key_evt_defs;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        WAIT2    = 3'd2,
        LONGHOLD = 3'd3,
        DBLHOLD  = 3'd4
    } key_state_t;

    localparam int DEF_CLK_PER_MS = 50000;
    localparam int DEF_LONG_MS    = 1000;
    localparam int DEF_DCLICK_MS  = 300;
    localparam int DEF_REPEAT_MS  = 200;

endpackage

// File: rtl/key_evt_timer.sv
// Gesture timer: N-bit up counter with synchronous clear,
// saturation at all-ones and a terminal compare against lim.
module key_evt_timer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] lim,
    output logic         hit
);

    logic [N-1:0] cnt;

    // count up, hold at all-ones, restart on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // terminal compare for the limit of the current state
    always_comb begin
        hit = (cnt == lim);
    end

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key gestures into short/long/double events.
// Build macro KEY_EVT_REPEAT_EN adds auto-repeat ticks in LONGHOLD.
import key_evt_defs::*;

module key_event_classifier #(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS,
    parameter int LONG_MS    = DEF_LONG_MS,
    parameter int DCLICK_MS  = DEF_DCLICK_MS,
    parameter int REPEAT_MS  = DEF_REPEAT_MS,
    parameter int N          = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic key_press,
    input  logic key_release,
    output logic evt_short,
    output logic evt_long,
    output logic evt_double,
    output logic evt_repeat,
    output logic busy
);

    localparam int LONG_T = LONG_MS * CLK_PER_MS;
    localparam int DCLK_T = DCLICK_MS * CLK_PER_MS;
    localparam int REP_T  = REPEAT_MS * CLK_PER_MS;

    localparam logic [N-1:0] LONG_LIM = N'(LONG_T - 1);
    localparam logic [N-1:0] DCLK_LIM = N'(DCLK_T - 1);
    localparam logic [N-1:0] REP_LIM  = N'(REP_T - 1);

    key_state_t   state;
    key_state_t   nxt;
    logic         press;
    logic         rel;
    logic         hit;
    logic         clr;
    logic         wrap;
    logic [N-1:0] lim;
    logic         nxt_short;
    logic         nxt_long;
    logic         nxt_double;
`ifdef KEY_EVT_REPEAT_EN
    logic         nxt_repeat;
`endif

    // a simultaneous press and release is treated as noise
    always_comb begin
        press = key_press & ~key_release;
        rel   = key_release & ~key_press;
    end

    // pick the terminal count that matters in the current state
    always_comb begin
        unique case (state)
            PRESS1:  lim = LONG_LIM;
            WAIT2:   lim = DCLK_LIM;
            default: lim = REP_LIM;
        endcase
    end

    // next-state and event decision; key edges beat timeouts
    always_comb begin
        nxt        = state;
        nxt_short  = 1'b0;
        nxt_long   = 1'b0;
        nxt_double = 1'b0;
        wrap       = 1'b0;
`ifdef KEY_EVT_REPEAT_EN
        nxt_repeat = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (press) nxt = PRESS1;
            end
            PRESS1: begin
                if (rel) begin
                    nxt = WAIT2;
                end else if (hit) begin
                    nxt      = LONGHOLD;
                    nxt_long = 1'b1;
                end
            end
            WAIT2: begin
                if (press) begin
                    nxt        = DBLHOLD;
                    nxt_double = 1'b1;
                end else if (hit) begin
                    nxt       = IDLE;
                    nxt_short = 1'b1;
                end
            end
            LONGHOLD: begin
                if (rel) begin
                    nxt = IDLE;
                end
`ifdef KEY_EVT_REPEAT_EN
                else if (hit) begin
                    nxt_repeat = 1'b1;
                    wrap       = 1'b1;
                end
`endif
            end
            DBLHOLD: begin
                if (rel) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        clr = (nxt != state) | wrap;
    end

    key_evt_timer #(
        .N(N)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .lim(lim),
        .hit(hit)
    );

    // state register and registered one-cycle event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            evt_short  <= 1'b0;
            evt_long   <= 1'b0;
            evt_double <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt;
            evt_short  <= nxt_short;
            evt_long   <= nxt_long;
            evt_double <= nxt_double;
            busy       <= (state != IDLE);
        end
    end

`ifdef KEY_EVT_REPEAT_EN
    // auto-repeat tick while a long press is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_repeat <= 1'b0;
        end else begin
            evt_repeat <= nxt_repeat;
        end
    end
`else
    assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed and random-gesture bench for key_event_classifier
// (LONG_T=100, DCLK_T=30, REP_T=20).
module tb_key_event_classifier;

    logic clk = 1'b0;
    logic rst;
    logic key_press;
    logic key_release;
    logic evt_short;
    logic evt_long;
    logic evt_double;
    logic evt_repeat;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc;
    int n_short, n_long, n_double, n_rep;
    int t_short, t_long, t_double, t_rep;
    int onehot_bad = 0;
    int presses;

`ifdef KEY_EVT_REPEAT_EN
    localparam int EXP_REP_N = 4;
    localparam int EXP_REP_T = 181;
`else
    localparam int EXP_REP_N = 0;
    localparam int EXP_REP_T = 0;
`endif

    key_event_classifier #(
        .CLK_PER_MS(10),
        .LONG_MS(10),
        .DCLICK_MS(3),
        .REPEAT_MS(2),
        .N(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_press(key_press),
        .key_release(key_release),
        .evt_short(evt_short),
        .evt_long(evt_long),
        .evt_double(evt_double),
        .evt_repeat(evt_repeat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        n_short = 0; n_long = 0; n_double = 0; n_rep = 0;
        t_short = 0; t_long = 0; t_double = 0; t_rep = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (evt_short === 1'b1) begin n_short++; t_short = cyc; end
        if (evt_long === 1'b1) begin n_long++; t_long = cyc; end
        if (evt_double === 1'b1) begin n_double++; t_double = cyc; end
        if (evt_repeat === 1'b1) begin n_rep++; t_rep = cyc; end
        if ($countones({evt_short, evt_long, evt_double, evt_repeat}) > 1)
            onehot_bad++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_press();
        key_press = 1'b1;
        tick();
        key_press = 1'b0;
    endtask

    task automatic do_release();
        key_release = 1'b1;
        tick();
        key_release = 1'b0;
    endtask

    initial begin
        int h, gap, hold2, code, exp_code;
        bit dbl;
        rst = 1'b1;
        key_press = 1'b0;
        key_release = 1'b0;
        clear_log();
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_evts", {evt_short, evt_long, evt_double, evt_repeat}, 0);
        rst = 1'b0;
        go_to(10);

        // short press
        clear_log();
        do_press();
        go_to(40);
        do_release();
        go_to(71);
        check("short_pulse71", evt_short, 1);
        check("short_busy71", busy, 1);
        tick();
        check("short_busy72", busy, 0);
        check("short_low72", evt_short, 0);
        go_to(90);
        check("short_count", n_short, 1);
        check("short_other", n_long + n_double + n_rep, 0);

        // long press held to cycle 200
        clear_log();
        do_press();
        go_to(101);
        check("long_pulse101", evt_long, 1);
        go_to(200);
        do_release();
        go_to(230);
        check("long_count", n_long, 1);
        check("long_time", t_long, 101);
        check("rep_count", n_rep, EXP_REP_N);
        check("rep_last", t_rep, EXP_REP_T);
        check("long_other", n_short + n_double, 0);
        check("long_busy", busy, 0);

        // double click
        clear_log();
        do_press();
        go_to(20);
        do_release();
        go_to(35);
        do_press();
        go_to(60);
        do_release();
        go_to(120);
        check("dbl_count", n_double, 1);
        check("dbl_time", t_double, 36);
        check("dbl_noshort", n_short + n_long, 0);
        check("dbl_busy", busy, 0);

        // second press on the timeout cycle
        clear_log();
        do_press();
        go_to(20);
        do_release();
        go_to(50);
        do_press();
        go_to(60);
        do_release();
        go_to(100);
        check("edge_dbl_time", t_double, 51);
        check("edge_noshort", n_short, 0);

        // release on the long threshold cycle
        clear_log();
        do_press();
        go_to(100);
        do_release();
        go_to(150);
        check("thr_nolong", n_long, 0);
        check("thr_short_time", t_short, 131);
        check("thr_short_n", n_short, 1);

        // simultaneous press/release in IDLE
        clear_log();
        key_press = 1'b1;
        key_release = 1'b1;
        tick();
        key_press = 1'b0;
        key_release = 1'b0;
        go_to(5);
        check("both_busy", busy, 0);
        check("both_evts", n_short + n_long + n_double + n_rep, 0);

        // reset during WAIT2
        clear_log();
        do_press();
        go_to(10);
        do_release();
        go_to(20);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_evts", {evt_short, evt_long, evt_double, evt_repeat}, 0);
        tick();
        tick();
        rst = 1'b0;
        go_to(80);
        check("mid_rst_noshort", n_short, 0);

        // random gesture stream
        presses = 0;
        while (presses < 500) begin
            clear_log();
            h = $urandom_range(1, 120);
            dbl = (h <= 100) && ($urandom_range(0, 2) == 0);
            do_press();
            presses++;
            go_to(h);
            do_release();
            if (dbl) begin
                gap = $urandom_range(1, 25);
                hold2 = $urandom_range(1, 20);
                go_to(h + gap);
                do_press();
                presses++;
                go_to(h + gap + hold2);
                do_release();
            end
            go_to(cyc + 40);
            if (h >= 101) exp_code = 100;
            else if (dbl) exp_code = 1;
            else exp_code = 10;
            code = n_long * 100 + n_short * 10 + n_double;
            check("rand_class", code, exp_code);
        end
        check("onehot", onehot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_classifier.md
Name: key_event_classifier

Overview:
- Sits directly downstream of the key debouncer in the cymometer front panel.
- Consumes the debouncer's one-cycle press/release pulses and classifies each gesture as one of: short press, long press, or double click.
- Emits one-cycle event pulses to the mode/range control logic.
- Keys are active-low. A press is the debounced falling edge; a release is the debounced rising edge.

Parameters:
- CLK_PER_MS, 50000, clk cycles per millisecond (50 MHz).
- LONG_MS, 1000, hold time that qualifies a press as long.
- DCLICK_MS, 300, maximum release-to-second-press gap for a double click.
- REPEAT_MS, 200, auto-repeat period while a long press is held (optional feature only).
- N, 32, timer width. Must hold LONG_MS*CLK_PER_MS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- key_press  in  1  one-cycle pulse, debounced key went down
- key_release  in  1  one-cycle pulse, debounced key went up
- evt_short  out  1  one-cycle pulse, short press classified
- evt_long  out  1  one-cycle pulse, long press threshold reached
- evt_double  out  1  one-cycle pulse, double click classified
- evt_repeat  out  1  one-cycle pulse, auto-repeat tick (tied 0 without the optional feature)
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: asynchronous, active-high, signal rst; clock clk. On reset: state=IDLE, timer=0, all evt_* outputs=0, busy=0.
- Localparams: LONG_T=LONG_MS*CLK_PER_MS, DCLK_T=DCLICK_MS*CLK_PER_MS, REP_T=REPEAT_MS*CLK_PER_MS.
- Input qualification: key_press and key_release asserted in the same cycle are both ignored.
- Timer: cleared on every state change; otherwise increments each cycle. Saturates at 2^N-1.
- State IDLE: key_press -> PRESS1. key_release is ignored.
- State PRESS1:
  - key_release with timer<LONG_T-1 -> WAIT2.
  - timer==LONG_T-1 -> LONGHOLD, with evt_long pulsed.
  - If the release and the threshold coincide, the release wins.
- State WAIT2:
  - key_press with timer<DCLK_T-1 -> DBLHOLD, with evt_double pulsed.
  - timer==DCLK_T-1 -> IDLE, with evt_short pulsed.
  - If the press and the timeout coincide, the press wins.
- State LONGHOLD: key_release -> IDLE, no event.
- State DBLHOLD: key_release -> IDLE, no event. A third press in DBLHOLD is ignored.
- Outputs are registered. Each evt_* asserts in the clock after the deciding condition and stays high exactly 1 cycle.
- At most one evt_* is high in any cycle.
- Latencies, counted from the key_press cycle k:
  - evt_long: cycle k+LONG_T+1.
  - evt_short: DCLK_T+1 cycles after the release cycle.
- A reset mid-gesture discards any pending classification; no event is emitted.

Optional Feature:
- Macro: KEY_EVT_REPEAT_EN.
- Defined: in LONGHOLD the timer restarts at each wrap; evt_repeat pulses every REP_T cycles. The first pulse comes REP_T cycles after evt_long. Pulses stop on key_release.
- Undefined: evt_repeat is held at constant 0 and no repeat logic is synthesised. LONGHOLD only waits for release.

Decomposition:
- Shared package/header key_evt_defs: state encodings (IDLE, PRESS1, WAIT2, LONGHOLD, DBLHOLD, 3-bit) and the default ms constants.
- Tick localparams stay local to the module.
- One sub-module: key_evt_timer, an N-bit counter with synchronous clear, saturation, and terminal-compare output for a supplied limit.
- The FSM and output registers stay in key_event_classifier.

Test Plan:
Bench parameters: CLK_PER_MS=10, LONG_MS=10, DCLICK_MS=3, REPEAT_MS=2, giving LONG_T=100, DCLK_T=30, REP_T=20.
- Press at cycle 0, release at cycle 40 -> evt_short single pulse at cycle 71. No other events. busy falls in cycle 72.
- Press at cycle 0, hold through cycle 200 -> evt_long at cycle 101. With the macro: evt_repeat at cycles 121, 141, 161, 181. Release at cycle 200 -> IDLE, no further pulses.
- Press at 0, release at 20, press at 35 -> evt_double at cycle 36. Release at 60 -> no evt_short, state IDLE.
- Release at 20, second press exactly at cycle 50 (timeout cycle) -> evt_double, not evt_short. Release coinciding with timer==99 in PRESS1 -> WAIT2, no evt_long.
- Press and release pulses in the same cycle in IDLE -> no state change. Assert rst while in WAIT2 -> outputs 0 immediately, no evt_short afterwards.
- Random gesture stream of 500 presses -> a checker confirms evt_* are one-hot and exactly one classification is emitted per gesture.
